if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipelined CPU, directly upstream of the decode stage. It owns the PC and drives a variable-latency instruction memory through a req/ready handshake. It holds the IF/ID pipeline register that feeds the decoder's inst input. It consumes the decoder's control and operand outputs (jump, jl, jr, branch, bne, target_instr, imm16, forwarded da/db) to resolve control flow, redirect fetch and flush the wrong-path instruction.

---
 rtl/if_stage_pkg.sv | 10 +
 rtl/pc_target.sv | 26 ++
 rtl/if_stage.sv | 137 +++++++++++++
 tb/tb_if_stage.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared constants and FSM state encoding for the fetch stage.
package if_stage_pkg;
   localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      KILL  = 2'd1,
      HELD  = 2'd2
   } if_state_t;
endpackage

// File: rtl/pc_target.sv
// pc_target: resolves control flow of the IF/ID instruction into a redirect flag and target PC.
module pc_target (
   input  logic        inst_valid,
   input  logic        stall,
   input  logic        jump,
   input  logic        jl,
   input  logic        jr,
   input  logic        branch,
   input  logic        bne,
   input  logic [25:0] target_instr,
   input  logic [15:0] imm16,
   input  logic [31:0] da,
   input  logic [31:0] db,
   input  logic [31:0] pc_plus4,
   output logic        redirect,
   output logic [31:0] target
);
   logic taken;
   always_comb begin
      taken    = branch & ((da == db) ^ bne);
      redirect = inst_valid & ~stall & (jr | jump | jl | taken);
      target   = jr ? da
               : (jump | jl) ? {pc_plus4[31:28], target_instr, 2'b00}
               : pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
   end
endmodule

// File: rtl/if_stage.sv
// if_stage: PC, variable-latency imem handshake, skid buffer and IF/ID register.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] inst,
   output logic [31:0] pc_plus4,
   output logic        inst_valid,
   input  logic        jump,
   input  logic        jl,
   input  logic        jr,
   input  logic        branch,
   input  logic        bne,
   input  logic [25:0] target_instr,
   input  logic [15:0] imm16,
   input  logic [31:0] da,
   input  logic [31:0] db
);
   if_state_t   state, state_n;
   logic [31:0] pc, pc_n, pc_pending, pend_n, skid_inst, skid_inst_n, skid_pc4, skid_pc4_n;
   logic [31:0] inst_n, pc4_n, pc_inc, target;
   logic        valid_n, redirect, bubble;

   pc_target u_pc_target (
      .inst_valid  (inst_valid),
      .stall       (stall),
      .jump        (jump),
      .jl          (jl),
      .jr          (jr),
      .branch      (branch),
      .bne         (bne),
      .target_instr(target_instr),
      .imm16       (imm16),
      .da          (da),
      .db          (db),
      .pc_plus4    (pc_plus4),
      .redirect    (redirect),
      .target      (target)
   );

   assign pc_inc    = pc + 32'd4;
   assign imem_addr = pc;
   assign imem_req  = ~reset & (state != HELD);

   always_comb begin
      state_n     = state;
      pc_n        = pc;
      pend_n      = pc_pending;
      skid_inst_n = skid_inst;
      skid_pc4_n  = skid_pc4;
      inst_n      = inst;
      pc4_n       = pc_plus4;
      valid_n     = inst_valid;
      bubble      = 1'b0;
      case (state)
         FETCH:
            if (imem_ready) begin
               if (redirect) begin
                  pc_n   = target;
                  bubble = 1'b1;
               end else if (stall) begin
                  skid_inst_n = imem_rdata;
                  skid_pc4_n  = pc_inc;
                  state_n     = HELD;
               end else begin
                  inst_n  = imem_rdata;
                  pc4_n   = pc_inc;
                  valid_n = 1'b1;
                  pc_n    = pc_inc;
               end
            end else if (redirect) begin
               pend_n  = target;
               state_n = KILL;
               bubble  = 1'b1;
            end else begin
               bubble = ~stall;
            end
         // The outstanding request must complete before the pending target is issued.
         KILL: begin
            if (imem_ready) begin
               pc_n    = pc_pending;
               state_n = FETCH;
            end
            bubble = ~stall;
         end
         HELD:
            if (!stall) begin
               state_n = FETCH;
               if (redirect) begin
                  pc_n   = target;
                  bubble = 1'b1;
               end else begin
                  inst_n  = skid_inst;
                  pc4_n   = skid_pc4;
                  valid_n = 1'b1;
                  pc_n    = skid_pc4;
               end
            end
         default: state_n = FETCH;
      endcase
      if (bubble) begin
         inst_n  = NOP_INST;
         valid_n = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         pc_pending <= RESET_PC;
         skid_inst  <= NOP_INST;
         skid_pc4   <= 32'd0;
         inst       <= NOP_INST;
         pc_plus4   <= 32'd0;
         inst_valid <= 1'b0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         pc_pending <= pend_n;
         skid_inst  <= skid_inst_n;
         skid_pc4   <= skid_pc4_n;
         inst       <= inst_n;
         pc_plus4   <= pc4_n;
         inst_valid <= valid_n;
      end
   end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of fetch, stall, branch, jump, jr-over-slow-fetch and reset.
module tb_if_stage;
   logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, imem_ready = 1'b1;
   logic        jump = 1'b0, jl = 1'b0, jr = 1'b0, branch = 1'b0, bne = 1'b0;
   logic [25:0] target_instr = '0;
   logic [15:0] imm16 = '0;
   logic [31:0] da = '0, db = '0;
   logic [31:0] imem_addr, imem_rdata, inst, pc_plus4;
   logic        imem_req, inst_valid;
   int          errs = 0, checks = 0;

   if_stage dut (
      .clk(clk), .reset(reset), .stall(stall),
      .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .inst(inst), .pc_plus4(pc_plus4), .inst_valid(inst_valid),
      .jump(jump), .jl(jl), .jr(jr), .branch(branch), .bne(bne),
      .target_instr(target_instr), .imm16(imm16), .da(da), .db(db)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a == 32'h0) ? 32'h2008_0005 : {16'hC0DE, a[15:0]};
   endfunction

   assign imem_rdata = mem(imem_addr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      {jump, jl, jr, branch, bne} = '0;
      target_instr = '0;
      imm16 = '0;
      da = '0;
      db = '0;
   endtask

   task automatic chk_if(input string tag, input logic [31:0] a, input logic [31:0] pc4, input logic [31:0] addr);
      chk({tag, "_inst"}, inst, mem(a));
      chk({tag, "_pc4"}, pc_plus4, pc4);
      chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
      chk({tag, "_addr"}, imem_addr, addr);
   endtask

   task automatic chk_bubble(input string tag, input logic [31:0] addr);
      chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
      chk({tag, "_inst"}, inst, 32'd0);
      chk({tag, "_addr"}, imem_addr, addr);
   endtask

   initial begin
      step();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_pc4", pc_plus4, 32'd0);
      step();
      chk("rst2_req", {31'd0, imem_req}, 32'd0);
      reset = 1'b0;
      #1;
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'h0);
      step();
      chk_if("s0", 32'h0, 32'h4, 32'h4);
      step();
      chk_if("s4", 32'h4, 32'h8, 32'h8);
      // stall for two cycles while the fetch of 0x8 returns
      stall = 1'b1;
      step();
      chk("held1_req", {31'd0, imem_req}, 32'd0);
      chk_if("held1", 32'h4, 32'h8, imem_addr);
      step();
      chk("held2_req", {31'd0, imem_req}, 32'd0);
      chk("held2_inst", inst, mem(32'h4));
      stall = 1'b0;
      step();
      chk_if("rel", 32'h8, 32'hC, 32'hC);
      chk("rel_req", {31'd0, imem_req}, 32'd1);
      step();
      chk_if("sC", 32'hC, 32'h10, 32'h10);
      step();
      chk_if("s10", 32'h10, 32'h14, 32'h14);
      // beq taken: 0x14 + (3<<2) = 0x20
      branch = 1'b1; da = 32'd7; db = 32'd7; imm16 = 16'h0003;
      step();
      clr();
      chk_bubble("beq", 32'h20);
      step();
      chk_if("s20", 32'h20, 32'h24, 32'h24);
      // jump to 0x3C so the next instruction has pc_plus4 = 0x40
      jump = 1'b1; target_instr = 26'h00000F;
      step();
      clr();
      chk_bubble("j3c", 32'h3C);
      step();
      chk_if("s3c", 32'h3C, 32'h40, 32'h40);
      // bne taken backward: 0x40 - 8 = 0x38
      bne = 1'b1; branch = 1'b1; da = 32'd1; db = 32'd2; imm16 = 16'hFFFE;
      step();
      clr();
      chk_bubble("bne", 32'h38);
      step();
      chk_if("s38", 32'h38, 32'h3C, 32'h3C);
      // bne not taken
      bne = 1'b1; branch = 1'b1; da = 32'd5; db = 32'd5; imm16 = 16'hFFFE;
      step();
      clr();
      chk_if("bne_nt", 32'h3C, 32'h40, 32'h40);
      // jal to 0x8, then run up to the fetch of 0x10
      jl = 1'b1; target_instr = 26'h000002;
      step();
      clr();
      chk_bubble("jl8", 32'h8);
      step();
      chk_if("s8b", 32'h8, 32'hC, 32'hC);
      step();
      chk_if("sCb", 32'hC, 32'h10, 32'h10);
      // jr while the fetch of 0x10 is held off for three cycles
      imem_ready = 1'b0; jr = 1'b1; da = 32'h100;
      step();
      clr();
      chk_bubble("kill1", 32'h10);
      chk("kill1_req", {31'd0, imem_req}, 32'd1);
      step();
      chk_bubble("kill2", 32'h10);
      step();
      chk_bubble("kill3", 32'h10);
      imem_ready = 1'b1;
      step();
      chk_bubble("kill_done", 32'h100);
      step();
      chk_if("s100", 32'h100, 32'h104, 32'h104);
      // reset while a fetch is outstanding
      imem_ready = 1'b0;
      step();
      chk_bubble("slow", 32'h104);
      reset = 1'b1;
      step();
      chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
      chk("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_addr", imem_addr, 32'h0);
      imem_ready = 1'b1;
      step();
      chk_if("post_rst", 32'h0, 32'h4, 32'h4);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
